// File: rtl/au_rr_arbiter.sv
// Round-robin arbiter sharing one AU datapath among WIDTH requesters.
// Holds a registered one-hot grant plus its binary index for the whole
// transfer, releases on last or when the owner drops its request, and can
// hand the resource straight to the next requester on the release edge.
module au_rr_arbiter #(
  parameter int WIDTH = 8,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] req,
  input  logic             last,
  output logic [WIDTH-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             busy
);

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "au_rr_arbiter: WIDTH must be >= 1");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  state_t           state_next;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    ptr_next;
  logic [WIDTH-1:0] grant_next;
  logic [IW-1:0]    idx_next;
  logic             rel;
  logic [IW-1:0]    new_ptr;
  logic [WIDTH-1:0] scan_req;
  logic [IW-1:0]    scan_start;
  logic             win_found;
  logic [IW-1:0]    win_idx;

  // Circular increment that wraps at WIDTH rather than at 2^IW.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    if (v == IW'(WIDTH - 1)) return '0;
    return v + IW'(1);
  endfunction

  // First set bit of r scanning circularly from start; returns {found, idx}.
  function automatic logic [IW:0] pick(input logic [IW-1:0] start,
                                       input logic [WIDTH-1:0] r);
    logic          found;
    logic [IW-1:0] pos;
    logic [IW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    pos   = start;
    for (int k = 0; k < WIDTH; k++) begin
      if (!found && r[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
      pos = wrap_inc(pos);
    end
    return {found, idx};
  endfunction

  assign busy = (state == BUSY);

  // Winner selection and next-state logic; while busy the scan starts just
  // past the owner and ignores the owner's own request so a release can
  // re-arbitrate on the same edge without regranting the same requester.
  always_comb begin
    rel        = last | ~req[grant_idx];
    new_ptr    = wrap_inc(grant_idx);
    scan_req   = req;
    scan_start = ptr;
    if (state == BUSY) begin
      scan_req[grant_idx] = 1'b0;
      scan_start          = new_ptr;
    end
    {win_found, win_idx} = pick(scan_start, scan_req);

    state_next = state;
    grant_next = grant;
    idx_next   = grant_idx;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (en && win_found) begin
          state_next = BUSY;
          grant_next = WIDTH'(1) << win_idx;
          idx_next   = win_idx;
        end
      end
      BUSY: begin
        if (rel) begin
          ptr_next = new_ptr;
          if (en && win_found) begin
            grant_next = WIDTH'(1) << win_idx;
            idx_next   = win_idx;
          end else begin
            state_next = IDLE;
            grant_next = '0;
            idx_next   = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, grant and priority pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_next;
      grant     <= grant_next;
      grant_idx <= idx_next;
      ptr       <= ptr_next;
    end
  end

endmodule

// File: doc/au_rr_arbiter.md
# au_rr_arbiter

Round-robin arbiter that shares one AU datapath resource among WIDTH requesters. It registers a one-hot grant and its binary-encoded index, which steers the shared unit's operand mux. The grant is held for a multi-cycle transfer and released on `last` or when the owner drops its request. Priority rotates so that every requester is served within WIDTH grants.

## Interface
- `WIDTH`, default 8: number of requesters (>= 1); any other value is illegal, and simulation prints an error and calls `$finish`.
- IW = max(ceil(log2(WIDTH)), 1): width of the encoded index (derived, not a parameter).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  arbitration enable; 0 blocks new grants but does not revoke the current one.
- `req`  in  WIDTH  request vector; bit i means requester i wants the resource.
- `last`  in  1  final cycle of the current owner's transfer; ignored when idle.
- `grant`  out  WIDTH  registered one-hot grant, all-zero when idle.
- `grant_idx`  out  IW  registered binary index of the set `grant` bit; 0 when idle.
- `busy`  out  1  registered; 1 when a grant is active (equals OR of `grant`).

## Operation
- State: `ptr` (IW bits, priority start position), `grant`, `grant_idx`, `busy`. There are two states:
  - IDLE (`busy`=0)
  - BUSY (`busy`=1)
- Reset values: `grant`=0, `grant_idx`=0, `busy`=0, `ptr`=0.
- Winner selection (combinational): scan `req` circularly starting at `ptr`, i.e. ptr, ptr+1, …, WIDTH-1, 0, …, ptr-1. The first set bit wins. Wrap-around is modulo WIDTH, not modulo 2^IW.
- IDLE -> BUSY: when `en`=1 and `req`!=0. The winner's one-hot goes to `grant` and its index to `grant_idx` at the next edge.
- IDLE with `en`=0 or `req`=0: stay IDLE; outputs hold at their idle values.
- BUSY: `grant` and `grant_idx` are held. The release condition is `rel` = `last` | ~`req[grant_idx]`. The second term is an abandon, with the same effect as `last`.
- On `rel`: `ptr` <= (`grant_idx`+1) mod WIDTH.
- Same-edge re-arbitration: when `rel`=1 and `en`=1, the next winner is selected from the current-cycle `req`, with bit `grant_idx` masked off, scanning from the new `ptr`.
  - If a winner exists: stay BUSY with the new grant. There is no idle bubble.
  - Otherwise: go to IDLE.
- On `rel` with `en`=0: go to IDLE.
- `ptr` changes only on release, never on a grant.
- `last` in IDLE has no effect.
- WIDTH=1: `grant_idx` is always 0 and `ptr` stays 0. After release, requester 0 can win again only from IDLE, so there is one idle cycle between back-to-back grants.
- `grant` is always zero or one-hot. `grant_idx` always equals the position of the set bit.

## Timing
- Request to grant latency: 1 cycle. `req` sampled at edge k gives `grant` valid after edge k.
- Release to next grant: 0 cycles. The release edge loads the new grant directly.
- Minimum grant length: 1 cycle. `last`=1 in the first BUSY cycle releases at the following edge.
- Reset has priority over all other inputs. `rst`=1 mid-transfer clears `grant`, `grant_idx`, `busy` and `ptr` at that edge, regardless of `last` or `req`.
- `en` falling while BUSY: the current transfer continues until `rel`, then the arbiter idles.
- All outputs come directly from flops, with no combinational path from inputs to outputs.

## Test plan
- Reset and single request:
  - Apply `rst` for 2 cycles, checking all outputs are 0.
  - Set `req`=8'b0000_0100 with `en`=1: after 1 edge, `grant`=8'h04, `grant_idx`=2, `busy`=1.
  - Pulse `last`: the next edge gives `busy`=0 and `ptr`=3.
- Rotation fairness: hold `req`=8'hFF and pulse `last` every 3rd cycle. Grants must come in order idx 0,1,2,…,7,0, each held exactly 3 cycles, with no idle cycle between them.
- Wrap and masking:
  - Grant idx 7 (`ptr`=7) with `req`=8'h81.
  - Pulse `last`: the next grant is idx 0 and `ptr`=0, not 8.
  - WIDTH=5: a grant at idx 4 followed by release gives `ptr`=0.
- Abandon and en gating:
  - Requester 3 drops `req` mid-transfer with no `last`: release occurs and `ptr`=4.
  - With `en`=0 and `req`=8'h10: `busy` stays 0 indefinitely.
  - Raise `en`: grant idx 4 one cycle later.
- Reset mid-operation and simultaneous events:
  - Assert `rst` in the same cycle as `last` while BUSY with `req`=8'hFF: the next edge gives all outputs 0 and `ptr`=0.
  - On deassertion, the first grant is idx 0.
- Invariant sweep over random `req`/`last`/`en` patterns for 10k cycles, checking:
  - `grant` is zero or one-hot.
  - `grant_idx` matches the `grant` position.
  - Every continuously asserted requester is granted within WIDTH releases.
  - WIDTH=1 and WIDTH=3 run the same checks.
